led_blink_multi: RTL

- Multi-channel LED driver with configurable modes; successor to the single-output fixed-rate blinker.
- One shared prescaler derives a slow tick from `clk`. Each of NUM_CH channels independently runs OFF, ON, BLINK or ONESHOT, with a per-channel period counted in ticks.
- Configured at runtime through a valid/ready write port. Sits between board-level control logic and LED pins.

---
 rtl/led_blink_pkg.sv | 24 ++
 rtl/led_blink_channel.sv | 95 +++++++++
 rtl/led_blink_multi.sv | 114 +++++++++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
package led_blink_pkg;

    // Per-channel operating mode, encoded exactly as the cfg_mode port.
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    // Width of a counter that must hold 0..(clk_hz/tick_hz)-1 (at least 1 bit).
    function automatic int presc_width(input int clk_hz, input int tick_hz);
        int div_v;
        int w_v;
        div_v = clk_hz / tick_hz;
        w_v   = 1;
        while ((w_v < 31) && ((longint'(1) << w_v) < longint'(div_v))) begin
            w_v = w_v + 1;
        end
        return w_v;
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: holds mode, period and phase, advances on prescaler ticks.
// A write always wins over a sync realign or a tick arriving in the same cycle.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_wr,
    input  mode_e            i_mode,
    input  logic [PER_W-1:0] i_period,
    input  logic             i_sync,
    output logic             o_state,
    output logic             o_done
);

    localparam logic [PER_W-1:0] ONE  = PER_W'(1);
    localparam logic [PER_W-1:0] ZERO = {PER_W{1'b0}};

    mode_e            r_mode;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_phase;
    logic             r_state;
    logic             r_done;

    logic [PER_W-1:0] w_period_eff;
    logic             w_last;

    // A zero period behaves as a one-tick period.
    always_comb begin
        w_period_eff = i_period;
        if (i_period == ZERO) begin
            w_period_eff = ONE;
        end else begin
            w_period_eff = i_period;
        end
    end

    // Phase is cleared at period-1, so it never wraps past the period register.
    assign w_last = (r_phase == (r_period - ONE));

    // Mode/phase state machine for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_OFF;
            r_period <= ONE;
            r_phase  <= ZERO;
            r_state  <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_wr) begin
            r_mode   <= i_mode;
            r_period <= w_period_eff;
            r_phase  <= ZERO;
            r_state  <= (i_mode != MODE_OFF);
            r_done   <= 1'b0;
        end else if (i_sync && (r_mode == MODE_BLINK)) begin
            r_phase <= ZERO;
            r_state <= 1'b1;
            r_done  <= 1'b0;
        end else if (i_tick) begin
            r_done <= 1'b0;
            case (r_mode)
                MODE_BLINK: begin
                    if (w_last) begin
                        r_phase <= ZERO;
                        r_state <= ~r_state;
                    end else begin
                        r_phase <= r_phase + ONE;
                    end
                end
                MODE_ONESHOT: begin
                    if (w_last) begin
                        r_phase <= ZERO;
                        r_state <= 1'b0;
                        r_mode  <= MODE_OFF;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + ONE;
                    end
                end
                default: begin
                    r_phase <= ZERO;
                end
            endcase
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_state = r_state;
    assign o_done  = r_done;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: shared prescaler, valid/ready config port,
// channel address decode and per-pin polarity mask.
// Optional build macro LED_BLINK_SYNC_EN adds the sync_strobe input, which
// restarts the prescaler and realigns every BLINK channel to phase 0, led on.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int                CLK_HZ         = 50000000,
    parameter int                TICK_HZ        = 1000,
    parameter int                NUM_CH         = 4,
    parameter int                PER_W          = 16,
    parameter logic [NUM_CH-1:0] LED_ACTIVE_LOW = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] done,
    output logic              tick
`ifdef LED_BLINK_SYNC_EN
    ,
    input  logic              sync_strobe
`endif
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = presc_width(CLK_HZ, TICK_HZ);
    localparam logic [PW-1:0] DIV_M1   = PW'(DIV - 1);
    localparam logic [4:0]    NUM_CH_W = 5'(NUM_CH);

    if (DIV < 2) begin : g_div_check
        $error("led_blink_multi: CLK_HZ/TICK_HZ must be at least 2");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_ch_check
        $error("led_blink_multi: NUM_CH must be in 1..16");
    end

    logic [PW-1:0]     r_presc;
    logic              r_ready;
    logic              r_err;

    logic              w_sync;
    logic              w_tick;
    logic              w_accept;
    logic              w_ch_ok;
    mode_e             w_mode;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_state;
    logic [NUM_CH-1:0] w_done;

`ifdef LED_BLINK_SYNC_EN
    assign w_sync = sync_strobe;
`else
    assign w_sync = 1'b0;
`endif

    // Tick is the decoded terminal count of the prescaler register.
    assign w_tick   = (r_presc == DIV_M1) && !w_sync;
    assign w_accept = cfg_valid && r_ready;
    assign w_ch_ok  = ({1'b0, cfg_ch} < NUM_CH_W);
    assign w_mode   = mode_e'(cfg_mode);

    // Shared prescaler counting 0..DIV-1; a sync strobe restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= {PW{1'b0}};
        end else if (w_sync || (r_presc == DIV_M1)) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Config handshake: ready drops for one cycle after each accept; flag bad channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= !w_accept;
            r_err   <= w_accept && !w_ch_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = w_accept && w_ch_ok && (cfg_ch == 4'(g));

        led_blink_channel #(
            .PER_W (PER_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_tick   (w_tick),
            .i_wr     (w_wr[g]),
            .i_mode   (w_mode),
            .i_period (cfg_period),
            .i_sync   (w_sync),
            .o_state  (w_state[g]),
            .o_done   (w_done[g])
        );
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = w_tick;
    assign led       = w_state ^ LED_ACTIVE_LOW;
    assign done      = w_done;

endmodule
